// File: rtl/zkey_event_sched_if.sv
// Switch pulse inputs and event-stream handshake of zkey_event_sched.
// master is the scheduler side, slave is the switch/consumer side.
interface zkey_event_sched_if #(
    parameter int NUM_SW = 4
);
    logic [NUM_SW-1:0] sw_down;
    logic [NUM_SW-1:0] sw_up;
    logic              evt_valid;
    logic [1:0]        evt_code;
    logic [1:0]        evt_sw;
    logic              evt_ready;
    logic              overflow;
    logic              clr_ovf;

    modport master (
        input  sw_down, sw_up, evt_ready, clr_ovf,
        output evt_valid, evt_code, evt_sw, overflow
    );

    modport slave (
        output sw_down, sw_up, evt_ready, clr_ovf,
        input  evt_valid, evt_code, evt_sw, overflow
    );
endinterface

// File: rtl/zkey_event_sched.sv
// Per-switch SHORT/LONG/LONG-RELEASE press classifier with a round-robin
// arbiter feeding one first-word-fall-through event FIFO.
module zkey_event_sched #(
    parameter int NUM_SW     = 4,
    parameter int LONG_CNT   = 100_000_000,
    parameter int CNT_W      = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               iClk,
    input  logic               iRstN,
    zkey_event_sched_if.master bus
);
    localparam int SW_W   = 2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10
    } press_state_t;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'b00,
        EVT_SHORT = 2'b01,
        EVT_LONG  = 2'b10,
        EVT_LREL  = 2'b11
    } evt_code_t;

    typedef struct packed {
        logic [SW_W-1:0] sw;
        evt_code_t       code;
    } fifo_entry_t;

    press_state_t      state_q     [NUM_SW];
    press_state_t      state_d     [NUM_SW];
    logic [CNT_W-1:0]  cnt_q       [NUM_SW];
    logic [CNT_W-1:0]  cnt_d       [NUM_SW];
    logic [NUM_SW-1:0] evt_fire;
    evt_code_t         evt_new     [NUM_SW];

    logic [NUM_SW-1:0] pend_valid_q;
    logic [NUM_SW-1:0] pend_valid_d;
    evt_code_t         pend_code_q [NUM_SW];
    evt_code_t         pend_code_d [NUM_SW];
    logic              ovf_set;
    logic              ovf_q;

    logic [SW_W-1:0]   last_grant_q;
    logic [NUM_SW-1:0] grant;
    logic              grant_any;
    logic [SW_W-1:0]   grant_idx;

    fifo_entry_t       mem [FIFO_DEPTH];
    fifo_entry_t       head;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_FW-1:0] count_q;
    logic              push;
    logic              pop;

    function automatic logic [SW_W-1:0] rr_idx(input logic [SW_W-1:0] base, input int off);
        return SW_W'((int'(base) + off) % NUM_SW);
    endfunction

    // Press classifier: one FSM and counter per channel.
    always_comb begin
        for (int n = 0; n < NUM_SW; n++) begin
            // NOTE: every combinational output gets a default first so no path can infer a latch.
            state_d[n]  = state_q[n];
            cnt_d[n]    = cnt_q[n];
            evt_fire[n] = 1'b0;
            evt_new[n]  = EVT_NONE;
            case (state_q[n])
                ST_IDLE: begin
                    if (bus.sw_down[n]) begin
                        cnt_d[n]   = '0;
                        state_d[n] = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                    if (bus.sw_up[n]) begin
                        evt_fire[n] = 1'b1;
                        evt_new[n]  = EVT_SHORT;
                        state_d[n]  = ST_IDLE;
                    end else if (cnt_q[n] == CNT_W'(LONG_CNT - 1)) begin
                        evt_fire[n] = 1'b1;
                        evt_new[n]  = EVT_LONG;
                        state_d[n]  = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (bus.sw_up[n]) begin
                        evt_fire[n] = 1'b1;
                        evt_new[n]  = EVT_LREL;
                        state_d[n]  = ST_IDLE;
                    end
                end
                default: state_d[n] = ST_IDLE;
            endcase
        end
    end

    // Round-robin grant, searching from the channel after the last winner.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        if (count_q < CNT_FW'(FIFO_DEPTH)) begin
            for (int i = 1; i <= NUM_SW; i++) begin
                if (!grant_any && pend_valid_q[rr_idx(last_grant_q, i)]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_idx(last_grant_q, i);
                end
            end
            if (grant_any) grant[grant_idx] = 1'b1;
        end
    end

    // A granted channel empties its slot this edge, so a new event may refill it.
    always_comb begin
        ovf_set = 1'b0;
        for (int n = 0; n < NUM_SW; n++) begin
            pend_valid_d[n] = pend_valid_q[n];
            pend_code_d[n]  = pend_code_q[n];
            if (evt_fire[n]) begin
                if (pend_valid_q[n] && !grant[n]) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_valid_d[n] = 1'b1;
                    pend_code_d[n]  = evt_new[n];
                end
            end else if (grant[n]) begin
                pend_valid_d[n] = 1'b0;
            end
        end
    end

    assign push = grant_any;
    assign pop  = bus.evt_valid & bus.evt_ready;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
            for (int n = 0; n < NUM_SW; n++) begin
                state_q[n]     <= ST_IDLE;
                cnt_q[n]       <= '0;
                pend_code_q[n] <= EVT_NONE;
            end
            pend_valid_q <= '0;
            last_grant_q <= SW_W'(NUM_SW - 1);
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            for (int n = 0; n < NUM_SW; n++) begin
                state_q[n]     <= state_d[n];
                cnt_q[n]       <= cnt_d[n];
                pend_code_q[n] <= pend_code_d[n];
            end
            pend_valid_q <= pend_valid_d;
            if (grant_any) last_grant_q <= grant_idx;
            if (ovf_set)             ovf_q <= 1'b1;
            else if (bus.clr_ovf)    ovf_q <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_FW'(1);
                2'b01:   count_q <= count_q - CNT_FW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; outputs are masked by evt_valid, so stale entries never show.
    always_ff @(posedge iClk) begin
        if (push) mem[wr_ptr_q] <= '{sw: grant_idx, code: pend_code_q[grant_idx]};
    end

    assign head          = mem[rd_ptr_q];
    assign bus.evt_valid = (count_q != '0);
    assign bus.evt_code  = bus.evt_valid ? head.code : EVT_NONE;
    assign bus.evt_sw    = bus.evt_valid ? head.sw   : '0;
    assign bus.overflow  = ovf_q;
endmodule
